// File: rtl/cpu_6502_rmw_ctrl.sv
// cpu_6502_rmw_ctrl: bus/ALU sequencer for 6502 read-modify-write instructions
// (ASL, LSR, ROL, ROR, INC, DEC on a memory operand).
// Sequence: IDLE -> READ -> DUMMY -> WRITE -> IDLE, with done pulsed back in IDLE.
// Build option: define CPU_6502_RMW_DUMMY_WRITE_EN for the NMOS dummy write of
// the unmodified byte during DUMMY. Left undefined, DUMMY is a second read
// (65C02 behaviour) and only the final byte is written.

package cpu_6502_rmw_pkg;

  // Shared ALU operation codes. ALU_ASL sits at zero so that the reset value of
  // the latched request drives an all-zero ALU op.
  typedef enum logic [3:0] {
    ALU_ASL = 4'd0,
    ALU_LSR = 4'd1,
    ALU_ROL = 4'd2,
    ALU_ROR = 4'd3,
    ALU_ADC = 4'd4,
    ALU_SBC = 4'd5,
    ALU_AND = 4'd6,
    ALU_ORA = 4'd7,
    ALU_EOR = 4'd8
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DUMMY = 2'd2,
    ST_WRITE = 2'd3
  } rmw_state_t;

  // Request op encodings from the decoder; 6 and 7 fall through to INC.
  localparam logic [2:0] RMW_ASL = 3'd0;
  localparam logic [2:0] RMW_LSR = 3'd1;
  localparam logic [2:0] RMW_ROL = 3'd2;
  localparam logic [2:0] RMW_ROR = 3'd3;
  localparam logic [2:0] RMW_DEC = 3'd5;

endpackage

module cpu_6502_rmw_ctrl
  import cpu_6502_rmw_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [2:0]  i_op,
  input  logic [15:0] i_addr,
  input  logic        i_carry,
  output logic [15:0] o_mem_addr,
  output logic        o_mem_we,
  output logic [7:0]  o_mem_wdata,
  input  logic [7:0]  i_mem_rdata,
  output alu_op_t     o_alu_op,
  output logic [7:0]  o_alu_lhs,
  output logic [7:0]  o_alu_rhs,
  output logic        o_alu_carry,
  output logic        o_alu_bcd,
  input  logic [7:0]  i_alu_result,
  input  logic        i_alu_carry,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_result,
  output logic        o_flag_n,
  output logic        o_flag_z,
  output logic        o_flag_c,
  output logic        o_flag_c_we
);

  rmw_state_t  state, state_nxt;
  logic [2:0]  op_q;
  logic [15:0] addr_q;
  logic        carry_q;
  logic [7:0]  operand_q;
  logic        accept;
  logic        is_shift;

  assign accept   = (state == ST_IDLE) && i_start;
  assign is_shift = (op_q == RMW_ASL) || (op_q == RMW_LSR) ||
                    (op_q == RMW_ROL) || (op_q == RMW_ROR);
  assign o_busy    = (state != ST_IDLE);
  assign o_alu_bcd = 1'b0;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic: fixed walk through the three bus cycles once started.
  // NOTE: every always_comb output is given a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (i_start) state_nxt = ST_READ;
      ST_READ:  state_nxt = ST_DUMMY;
      ST_DUMMY: state_nxt = ST_WRITE;
      ST_WRITE: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Latch the request on acceptance; later changes on the inputs are ignored.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      op_q    <= 3'd0;
      addr_q  <= 16'h0000;
      carry_q <= 1'b0;
    end else if (accept) begin
      op_q    <= i_op;
      addr_q  <= i_addr;
      carry_q <= i_carry;
    end
  end

  // Operand register: read data arrives one cycle after READ, i.e. in DUMMY.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                 operand_q <= 8'h00;
    else if (state == ST_DUMMY)  operand_q <= i_mem_rdata;
  end

  // Completion: capture result and flags at the end of WRITE, pulse done.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_done      <= 1'b0;
      o_flag_c_we <= 1'b0;
      o_result    <= 8'h00;
      o_flag_n    <= 1'b0;
      o_flag_z    <= 1'b0;
      o_flag_c    <= 1'b0;
    end else begin
      o_done      <= (state == ST_WRITE);
      o_flag_c_we <= (state == ST_WRITE) && is_shift;
      if (state == ST_WRITE) begin
        o_result <= i_alu_result;
        o_flag_n <= i_alu_result[7];
        o_flag_z <= (i_alu_result == 8'h00);
        o_flag_c <= i_alu_carry;
      end
    end
  end

  // Bus drive per state; the bus is parked at zero while idle.
  always_comb begin
    o_mem_addr  = 16'h0000;
    o_mem_we    = 1'b0;
    o_mem_wdata = 8'h00;
    case (state)
      ST_READ: o_mem_addr = addr_q;
      ST_DUMMY: begin
        o_mem_addr = addr_q;
`ifdef CPU_6502_RMW_DUMMY_WRITE_EN
        o_mem_we    = 1'b1;
        o_mem_wdata = i_mem_rdata;
`endif
      end
      ST_WRITE: begin
        o_mem_addr  = addr_q;
        o_mem_we    = 1'b1;
        o_mem_wdata = i_alu_result;
      end
      default: ;
    endcase
  end

  // ALU drive from the latched op and operand; INC/DEC are plain binary adds.
  always_comb begin
    o_alu_op    = ALU_ASL;
    o_alu_lhs   = operand_q;
    o_alu_rhs   = 8'h00;
    o_alu_carry = carry_q;
    case (op_q)
      RMW_ASL: o_alu_op = ALU_ASL;
      RMW_LSR: o_alu_op = ALU_LSR;
      RMW_ROL: o_alu_op = ALU_ROL;
      RMW_ROR: o_alu_op = ALU_ROR;
      RMW_DEC: begin
        o_alu_op    = ALU_ADC;
        o_alu_rhs   = 8'hFF;
        o_alu_carry = 1'b0;
      end
      default: begin
        o_alu_op    = ALU_ADC;
        o_alu_rhs   = 8'h01;
        o_alu_carry = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_6502_rmw_ctrl.sv
// Directed testbench for cpu_6502_rmw_ctrl with a registered memory model and
// a reference model of the shared ALU. Expectations follow the build option
// CPU_6502_RMW_DUMMY_WRITE_EN.

module tb_cpu_6502_rmw_ctrl;
  import cpu_6502_rmw_pkg::*;

`ifdef CPU_6502_RMW_DUMMY_WRITE_EN
  localparam logic EXP_DUMMY_WE = 1'b1;
  localparam int   EXP_WRITES   = 2;
`else
  localparam logic EXP_DUMMY_WE = 1'b0;
  localparam int   EXP_WRITES   = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] addr = 16'h0000;
  logic        carry = 1'b0;
  logic [15:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  alu_op_t     alu_op;
  logic [7:0]  alu_lhs, alu_rhs;
  logic        alu_cin, alu_bcd;
  logic [7:0]  alu_res;
  logic        alu_cout;
  logic        busy, done;
  logic [7:0]  result;
  logic        flag_n, flag_z, flag_c, flag_c_we;

  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = 16'h0000;
  logic [7:0]  poke_data = 8'h00;
  logic [7:0]  mem [0:65535];
  int          wr_cnt = 0;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cpu_6502_rmw_ctrl dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_start      (start),
    .i_op         (op),
    .i_addr       (addr),
    .i_carry      (carry),
    .o_mem_addr   (mem_addr),
    .o_mem_we     (mem_we),
    .o_mem_wdata  (mem_wdata),
    .i_mem_rdata  (mem_rdata),
    .o_alu_op     (alu_op),
    .o_alu_lhs    (alu_lhs),
    .o_alu_rhs    (alu_rhs),
    .o_alu_carry  (alu_cin),
    .o_alu_bcd    (alu_bcd),
    .i_alu_result (alu_res),
    .i_alu_carry  (alu_cout),
    .o_busy       (busy),
    .o_done       (done),
    .o_result     (result),
    .o_flag_n     (flag_n),
    .o_flag_z     (flag_z),
    .o_flag_c     (flag_c),
    .o_flag_c_we  (flag_c_we)
  );

  // Registered memory: read data valid the cycle after the address; writes counted.
  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr_cnt        <= wr_cnt + 1;
    end
    mem_rdata <= mem[mem_addr];
  end

  // Reference ALU.
  always_comb begin
    alu_res  = 8'h00;
    alu_cout = 1'b0;
    case (alu_op)
      ALU_ASL: {alu_cout, alu_res} = {alu_lhs, 1'b0};
      ALU_LSR: {alu_res, alu_cout} = {1'b0, alu_lhs};
      ALU_ROL: {alu_cout, alu_res} = {alu_lhs, alu_cin};
      ALU_ROR: {alu_res, alu_cout} = {alu_cin, alu_lhs};
      ALU_ADC: {alu_cout, alu_res} = {1'b0, alu_lhs} + {1'b0, alu_rhs} + {8'h00, alu_cin};
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [15:0] a, input logic [7:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    step();
    poke_en = 1'b0;
  endtask

  // One full operation, checked cycle by cycle from C0 to the cycle after C4.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [15:0] a,
                        input logic cin, input logic [7:0] init, input logic [7:0] res,
                        input logic n, input logic z, input logic c, input logic cwe,
                        input alu_op_t exp_alu, input logic [7:0] exp_rhs, input logic exp_cin);
    int base;
    poke(a, init);
    base  = wr_cnt;
    start = 1'b1; op = o; addr = a; carry = cin;
    step();                                           // C1 READ
    start = 1'b0; op = o ^ 3'd1; addr = 16'hBEEF; carry = ~cin;
    check({tag, " C1 busy"}, 16'(busy), 16'h1);
    check({tag, " C1 addr"}, mem_addr, a);
    check({tag, " C1 we"}, 16'(mem_we), 16'h0);
    step();                                           // C2 DUMMY
    check({tag, " C2 addr"}, mem_addr, a);
    check({tag, " C2 we"}, 16'(mem_we), 16'(EXP_DUMMY_WE));
    if (EXP_DUMMY_WE) check({tag, " C2 wdata"}, 16'(mem_wdata), 16'(init));
    step();                                           // C3 WRITE
    check({tag, " C3 we"}, 16'(mem_we), 16'h1);
    check({tag, " C3 wdata"}, 16'(mem_wdata), 16'(res));
    check({tag, " C3 alu_op"}, 16'(alu_op), 16'(exp_alu));
    check({tag, " C3 alu_rhs"}, 16'(alu_rhs), 16'(exp_rhs));
    check({tag, " C3 alu_cin"}, 16'(alu_cin), 16'(exp_cin));
    check({tag, " C3 bcd"}, 16'(alu_bcd), 16'h0);
    check({tag, " C3 done"}, 16'(done), 16'h0);
    step();                                           // C4 IDLE, done
    check({tag, " C4 done"}, 16'(done), 16'h1);
    check({tag, " C4 busy"}, 16'(busy), 16'h0);
    check({tag, " C4 addr"}, mem_addr, 16'h0000);
    check({tag, " result"}, 16'(result), 16'(res));
    check({tag, " N"}, 16'(flag_n), 16'(n));
    check({tag, " Z"}, 16'(flag_z), 16'(z));
    check({tag, " C"}, 16'(flag_c), 16'(c));
    check({tag, " c_we"}, 16'(flag_c_we), 16'(cwe));
    check({tag, " mem"}, 16'(mem[a]), 16'(res));
    check({tag, " writes"}, 16'(wr_cnt - base), 16'(EXP_WRITES));
    step();                                           // after the pulse
    check({tag, " done pulse"}, 16'(done), 16'h0);
    check({tag, " c_we pulse"}, 16'(flag_c_we), 16'h0);
    check({tag, " result held"}, 16'(result), 16'(res));
  endtask

  initial begin
    int  base;
    logic done_seen;

    // Reset state.
    #2;
    check("rst done", 16'(done), 16'h0);
    check("rst busy", 16'(busy), 16'h0);
    check("rst we", 16'(mem_we), 16'h0);
    check("rst addr", mem_addr, 16'h0000);
    check("rst wdata", 16'(mem_wdata), 16'h0);
    check("rst result", 16'(result), 16'h0);
    check("rst flags", {13'b0, flag_n, flag_z, flag_c}, 16'h0);
    check("rst c_we", 16'(flag_c_we), 16'h0);
    check("rst alu_op", 16'(alu_op), 16'h0);
    check("rst alu_lhs", 16'(alu_lhs), 16'h0);
    check("rst alu_rhs", 16'(alu_rhs), 16'h0);
    check("rst alu_cin", 16'(alu_cin), 16'h0);
    step();
    rst = 1'b0;
    step();

    run_op("ASL", 3'd0, 16'h0200, 1'b0, 8'h81, 8'h02, 1'b0, 1'b0, 1'b1, 1'b1, ALU_ASL, 8'h00, 1'b0);
    run_op("LSR", 3'd1, 16'h0201, 1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, ALU_LSR, 8'h00, 1'b1);
    run_op("ROL", 3'd2, 16'h0202, 1'b1, 8'h40, 8'h81, 1'b1, 1'b0, 1'b0, 1'b1, ALU_ROL, 8'h00, 1'b1);
    run_op("ROR", 3'd3, 16'h0010, 1'b1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b1, 1'b1, ALU_ROR, 8'h00, 1'b1);

    // Reset during DUMMY: immediate bus release, no write, no done.
    poke(16'h0400, 8'h55);
    base  = wr_cnt;
    start = 1'b1; op = 3'd0; addr = 16'h0400; carry = 1'b0;
    step();
    start = 1'b0;
    step();
    check("mid C2 addr", mem_addr, 16'h0400);
    rst = 1'b1;
    #1;
    check("mid we", 16'(mem_we), 16'h0);
    check("mid busy", 16'(busy), 16'h0);
    check("mid addr", mem_addr, 16'h0000);
    check("mid result", 16'(result), 16'h0);
    check("mid flags", {13'b0, flag_n, flag_z, flag_c}, 16'h0);
    check("mid alu_lhs", 16'(alu_lhs), 16'h0);
    step();
    rst = 1'b0;
    done_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done || busy) done_seen = 1'b1;
    end
    check("mid no activity", 16'(done_seen), 16'h0);
    check("mid mem", 16'(mem[16'h0400]), 16'h55);
    check("mid writes", 16'(wr_cnt - base), 16'h0);

    run_op("INC", 3'd4, 16'h0020, 1'b1, 8'hFF, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, ALU_ADC, 8'h01, 1'b0);
    run_op("DEC", 3'd5, 16'h0021, 1'b1, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, ALU_ADC, 8'hFF, 1'b0);
    run_op("OP7", 3'd7, 16'h0022, 1'b0, 8'h41, 8'h42, 1'b0, 1'b0, 1'b0, 1'b0, ALU_ADC, 8'h01, 1'b0);

    // Start held high with a changing address: second op accepted in C4.
    poke(16'h0300, 8'h10);
    poke(16'h0301, 8'hAA);
    poke(16'h0302, 8'hAA);
    poke(16'h0303, 8'hAA);
    poke(16'h0304, 8'h20);
    start = 1'b1; op = 3'd4; addr = 16'h0300; carry = 1'b0;
    step(); addr = 16'h0301;                          // C1
    check("held C1 addr", mem_addr, 16'h0300);
    step(); addr = 16'h0302;                          // C2
    check("held C2 addr", mem_addr, 16'h0300);
    step(); addr = 16'h0303;                          // C3
    check("held C3 addr", mem_addr, 16'h0300);
    check("held C3 wdata", 16'(mem_wdata), 16'h11);
    step(); addr = 16'h0304;                          // C4
    check("held C4 done", 16'(done), 16'h1);
    check("held C4 busy", 16'(busy), 16'h0);
    check("held C4 result", 16'(result), 16'h11);
    step(); start = 1'b0; addr = 16'h0000;            // C5
    check("held C5 busy", 16'(busy), 16'h1);
    check("held C5 addr", mem_addr, 16'h0304);
    step();                                           // C6
    step();                                           // C7
    check("held C7 wdata", 16'(mem_wdata), 16'h21);
    step();                                           // C8
    check("held C8 done", 16'(done), 16'h1);
    check("held C8 result", 16'(result), 16'h21);
    check("held mem 0300", 16'(mem[16'h0300]), 16'h11);
    check("held mem 0304", 16'(mem[16'h0304]), 16'h21);
    check("held mem 0303", 16'(mem[16'h0303]), 16'hAA);
    step();
    check("held idle", 16'(busy), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
